// File: rtl/wb_stage.sv
// Write-back stage: load formatting, GPR write port, committed CP0 subset and flush/redirect.
// Optional CP0 Count/Compare timer is enabled with `define WB_COUNT_EN.
module wb_stage #(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
    parameter logic [31:0] STATUS_RST = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_valid_in,
    output logic        wb_allowin_out,
    input  logic [31:0] mem_PC_in,
    input  logic [31:0] mem_dm_data_in,
    input  logic [4:0]  mem_wnum_in,
    input  logic [2:0]  mem_sel_wbdata_in,
    input  logic [7:0]  mem_onehot_in,
    input  logic [4:0]  mem_lubhw_con_in,
    input  logic [1:0]  mem_adrl_in,
    input  logic [2:0]  mem_write_type_in,
    input  logic [31:0] mem_wbdata_in,
    input  logic [3:0]  mem_llr_we_in,
    input  logic [31:0] rt_old_in,
    input  logic        mem_exception_in,
    input  logic        mem_bd_in,
    input  logic [4:0]  mem_ExcCode_in,
    input  logic [7:0]  mem_cp0_addr_in,
    input  logic [31:0] mem_mtc0_data_in,
    input  logic [31:0] mem_error_VAddr_in,
    input  logic        mem_eret_in,
    input  logic [1:0]  mem_mftc0_op_in,
    output logic        wb_ClrStpJmp_out,
    output logic [31:0] wb_new_pc_out,
    output logic        rf_we_out,
    output logic [4:0]  rf_wnum_out,
    output logic [31:0] rf_wdata_out,
    output logic [31:0] debug_wb_pc,
    output logic [3:0]  debug_wb_rf_wen,
    output logic [4:0]  debug_wb_rf_wnum,
    output logic [31:0] debug_wb_rf_wdata
);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
        logic [4:0]  wnum;
        logic [2:0]  sel;
        logic [7:0]  onehot;
        logic [4:0]  lubhw;
        logic [1:0]  adrl;
        logic [2:0]  wtype;
        logic [31:0] wbdata;
        logic [3:0]  llr_we;
        logic        exc;
        logic        bd;
        logic [4:0]  code;
        logic [7:0]  cp0_addr;
        logic [31:0] mtc0_data;
        logic [31:0] vaddr;
        logic        eret;
        logic [1:0]  op;
    } fields_t;

    localparam logic [31:0] StatusWrMask = 32'h0000_FF03;
    localparam logic [31:0] CauseWrMask  = 32'h0000_0300;

    fields_t     f_d, f_q;
    logic        valid_q;
    logic [31:0] status_d, status_q, cause_d, cause_q, epc_d, epc_q, badv_d, badv_q;
    logic        kill, cp0_we;
    logic [31:0] cause_rd, count_rd, compare_rd, cp0_rdata;
    logic [31:0] byte_w, load_w, shifted, merge_w, result;

    assign f_d = '{pc: mem_PC_in, data: mem_dm_data_in, wnum: mem_wnum_in,
                   sel: mem_sel_wbdata_in, onehot: mem_onehot_in, lubhw: mem_lubhw_con_in,
                   adrl: mem_adrl_in, wtype: mem_write_type_in, wbdata: mem_wbdata_in,
                   llr_we: mem_llr_we_in, exc: mem_exception_in, bd: mem_bd_in,
                   code: mem_ExcCode_in, cp0_addr: mem_cp0_addr_in,
                   mtc0_data: mem_mtc0_data_in, vaddr: mem_error_VAddr_in,
                   eret: mem_eret_in, op: mem_mftc0_op_in};

    assign kill   = valid_q && (f_q.exc || f_q.eret);
    assign cp0_we = valid_q && !kill && f_q.op[1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            f_q      <= '0;
            status_q <= STATUS_RST;
            cause_q  <= '0;
            epc_q    <= '0;
            badv_q   <= '0;
        end else begin
            valid_q  <= mem_valid_in && !kill;
            f_q      <= mem_valid_in ? f_d : '0;
            status_q <= status_d;
            cause_q  <= cause_d;
            epc_q    <= epc_d;
            badv_q   <= badv_d;
        end
    end

    always_comb begin
        status_d = status_q;
        cause_d  = cause_q;
        epc_d    = epc_q;
        badv_d   = badv_q;
        if (valid_q && f_q.exc) begin
            // Nested exceptions keep the original EPC and BD.
            if (!status_q[1]) begin
                epc_d      = f_q.bd ? f_q.pc - 32'd4 : f_q.pc;
                cause_d[31] = f_q.bd;
            end
            cause_d[6:2] = f_q.code;
            status_d[1]  = 1'b1;
            if (f_q.code == 5'd4 || f_q.code == 5'd5) badv_d = f_q.vaddr;
        end else if (valid_q && f_q.eret) begin
            status_d[1] = 1'b0;
        end else if (cp0_we) begin
            case (f_q.cp0_addr)
                8'h60:   status_d = (status_q & ~StatusWrMask) | (f_q.mtc0_data & StatusWrMask);
                8'h68:   cause_d  = (cause_q & ~CauseWrMask) | (f_q.mtc0_data & CauseWrMask);
                8'h70:   epc_d    = f_q.mtc0_data;
                default: ;
            endcase
        end
    end

`ifdef WB_COUNT_EN
    logic        tick_q, ti_d, ti_q;
    logic [31:0] count_d, count_q, compare_d, compare_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tick_q    <= 1'b0;
            ti_q      <= 1'b0;
            count_q   <= '0;
            compare_q <= '0;
        end else begin
            tick_q    <= ~tick_q;
            ti_q      <= ti_d;
            count_q   <= count_d;
            compare_q <= compare_d;
        end
    end

    always_comb begin
        count_d   = count_q + {31'b0, tick_q};
        compare_d = compare_q;
        ti_d      = ti_q;
        if (cp0_we && f_q.cp0_addr == 8'h48) count_d = f_q.mtc0_data;
        if (cp0_we && f_q.cp0_addr == 8'h58) begin
            compare_d = f_q.mtc0_data;
            ti_d      = 1'b0;
        end else if (count_q == compare_q) begin
            ti_d = 1'b1;
        end
    end

    assign cause_rd   = {cause_q[31], ti_q, cause_q[29:16], ti_q, cause_q[14:0]};
    assign count_rd   = count_q;
    assign compare_rd = compare_q;
`else
    assign cause_rd   = cause_q;
    assign count_rd   = '0;
    assign compare_rd = '0;
`endif

    always_comb begin
        case (f_q.cp0_addr)
            8'h60:   cp0_rdata = status_q;
            8'h68:   cp0_rdata = cause_rd;
            8'h70:   cp0_rdata = epc_q;
            8'h40:   cp0_rdata = badv_q;
            8'h48:   cp0_rdata = count_rd;
            8'h58:   cp0_rdata = compare_rd;
            default: cp0_rdata = '0;
        endcase
    end

    always_comb begin
        byte_w = f_q.data >> {f_q.adrl, 3'b000};
        load_w = '0;
        if (f_q.lubhw[0])      load_w = {{24{byte_w[7]}}, byte_w[7:0]};
        else if (f_q.lubhw[1]) load_w = {24'b0, byte_w[7:0]};
        else if (f_q.lubhw[2]) load_w = {{16{byte_w[15]}}, byte_w[15:0]};
        else if (f_q.lubhw[3]) load_w = {16'b0, byte_w[15:0]};
        else if (f_q.lubhw[4]) load_w = f_q.data;
    end

    always_comb begin
        shifted = '0;
        for (int i = 0; i < 4; i++) begin
            if (f_q.onehot[i])     shifted = f_q.data << 5'(8 * (3 - i));
            if (f_q.onehot[i + 4]) shifted = f_q.data >> 5'(8 * i);
        end
        for (int i = 0; i < 4; i++) begin
            merge_w[8*i +: 8] = f_q.llr_we[i] ? shifted[8*i +: 8] : rt_old_in[8*i +: 8];
        end
    end

    always_comb begin
        if (f_q.op[0])       result = cp0_rdata;
        else if (f_q.sel[2]) result = merge_w;
        else if (f_q.sel[1]) result = load_w;
        else if (f_q.sel[0]) result = f_q.wbdata;
        else                 result = '0;
    end

    assign wb_allowin_out    = 1'b1;
    assign wb_ClrStpJmp_out  = kill;
    // ERET flagged together with an exception takes the exception vector.
    assign wb_new_pc_out     = !kill ? '0 : (f_q.eret && !f_q.exc) ? epc_q : EXC_VECTOR;
    assign rf_we_out         = valid_q && !f_q.exc && !f_q.eret && (f_q.wtype != 3'd0)
                               && (f_q.wnum != 5'd0);
    assign rf_wnum_out       = f_q.wnum;
    assign rf_wdata_out      = result;
    assign debug_wb_pc       = valid_q ? f_q.pc : '0;
    assign debug_wb_rf_wen   = {4{rf_we_out}};
    assign debug_wb_rf_wnum  = f_q.wnum;
    assign debug_wb_rf_wdata = result;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus randomized traffic
// compared against a transaction-level reference model.
module tb_wb_stage;

    localparam logic [31:0] ExcVector = 32'hBFC0_0380;
    localparam logic [31:0] StatusRst = 32'h0040_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
        logic [4:0]  wnum;
        logic [2:0]  sel;
        logic [7:0]  onehot;
        logic [4:0]  lubhw;
        logic [1:0]  adrl;
        logic [2:0]  wtype;
        logic [31:0] wbdata;
        logic [3:0]  llr;
        logic        exc;
        logic        bd;
        logic [4:0]  code;
        logic [7:0]  cp0a;
        logic [31:0] mtc0d;
        logic [31:0] vaddr;
        logic        eret;
        logic [1:0]  op;
    } tr_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_valid_in;
    logic        wb_allowin_out;
    logic [31:0] mem_PC_in, mem_dm_data_in, mem_wbdata_in, rt_old_in;
    logic [4:0]  mem_wnum_in, mem_lubhw_con_in, mem_ExcCode_in;
    logic [2:0]  mem_sel_wbdata_in, mem_write_type_in;
    logic [7:0]  mem_onehot_in, mem_cp0_addr_in;
    logic [1:0]  mem_adrl_in, mem_mftc0_op_in;
    logic [3:0]  mem_llr_we_in;
    logic        mem_exception_in, mem_bd_in, mem_eret_in;
    logic [31:0] mem_mtc0_data_in, mem_error_VAddr_in;
    logic        wb_ClrStpJmp_out, rf_we_out;
    logic [31:0] wb_new_pc_out, rf_wdata_out, debug_wb_pc, debug_wb_rf_wdata;
    logic [4:0]  rf_wnum_out, debug_wb_rf_wnum;
    logic [3:0]  debug_wb_rf_wen;

    always #5 clk = ~clk;

    wb_stage dut (
        .clk(clk), .rst_n(rst_n), .mem_valid_in(mem_valid_in), .wb_allowin_out(wb_allowin_out),
        .mem_PC_in(mem_PC_in), .mem_dm_data_in(mem_dm_data_in), .mem_wnum_in(mem_wnum_in),
        .mem_sel_wbdata_in(mem_sel_wbdata_in), .mem_onehot_in(mem_onehot_in),
        .mem_lubhw_con_in(mem_lubhw_con_in), .mem_adrl_in(mem_adrl_in),
        .mem_write_type_in(mem_write_type_in), .mem_wbdata_in(mem_wbdata_in),
        .mem_llr_we_in(mem_llr_we_in), .rt_old_in(rt_old_in),
        .mem_exception_in(mem_exception_in), .mem_bd_in(mem_bd_in),
        .mem_ExcCode_in(mem_ExcCode_in), .mem_cp0_addr_in(mem_cp0_addr_in),
        .mem_mtc0_data_in(mem_mtc0_data_in), .mem_error_VAddr_in(mem_error_VAddr_in),
        .mem_eret_in(mem_eret_in), .mem_mftc0_op_in(mem_mftc0_op_in),
        .wb_ClrStpJmp_out(wb_ClrStpJmp_out), .wb_new_pc_out(wb_new_pc_out),
        .rf_we_out(rf_we_out), .rf_wnum_out(rf_wnum_out), .rf_wdata_out(rf_wdata_out),
        .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: the instruction currently in WB plus architectural CP0 state.
    logic        m_valid;
    tr_t         m_r;
    logic [31:0] m_status, m_cause, m_epc, m_badv;

    function automatic logic [31:0] cp0_read(input logic [7:0] a);
        case (a)
            8'h60:   return m_status;
            8'h68:   return m_cause;
            8'h70:   return m_epc;
            8'h40:   return m_badv;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] exp_result(input tr_t r, input logic [31:0] rt);
        logic [31:0] sh, b, res;
        if (r.op[0]) return cp0_read(r.cp0a);
        if (r.sel[2]) begin
            sh = 32'h0;
            for (int a = 0; a < 4; a++) begin
                if (r.onehot[a])     sh = r.data << (8 * (3 - a));
                if (r.onehot[a + 4]) sh = r.data >> (8 * a);
            end
            for (int i = 0; i < 4; i++) res[8*i +: 8] = r.llr[i] ? sh[8*i +: 8] : rt[8*i +: 8];
            return res;
        end
        if (r.sel[1]) begin
            b = r.data >> (8 * int'(r.adrl));
            if (r.lubhw[0]) return 32'($signed(b[7:0]));
            if (r.lubhw[1]) return {24'h0, b[7:0]};
            if (r.lubhw[2]) return 32'($signed(b[15:0]));
            if (r.lubhw[3]) return {16'h0, b[15:0]};
            if (r.lubhw[4]) return r.data;
            return 32'h0;
        end
        if (r.sel[0]) return r.wbdata;
        return 32'h0;
    endfunction

    task automatic model_edge(input tr_t t, input logic v);
        logic kill;
        if (!rst_n) begin
            m_valid = 1'b0; m_r = '0;
            m_status = StatusRst; m_cause = 0; m_epc = 0; m_badv = 0;
            return;
        end
        kill = m_valid && (m_r.exc || m_r.eret);
        if (m_valid && m_r.exc) begin
            if (!m_status[1]) begin
                m_epc = m_r.bd ? m_r.pc - 4 : m_r.pc;
                m_cause[31] = m_r.bd;
            end
            m_cause[6:2] = m_r.code;
            m_status[1] = 1'b1;
            if (m_r.code == 5'd4 || m_r.code == 5'd5) m_badv = m_r.vaddr;
        end else if (m_valid && m_r.eret) begin
            m_status[1] = 1'b0;
        end else if (m_valid && m_r.op[1]) begin
            if (m_r.cp0a == 8'h60) begin
                m_status[15:8] = m_r.mtc0d[15:8];
                m_status[1:0]  = m_r.mtc0d[1:0];
            end
            if (m_r.cp0a == 8'h68) m_cause[9:8] = m_r.mtc0d[9:8];
            if (m_r.cp0a == 8'h70) m_epc = m_r.mtc0d;
        end
        m_valid = v && !kill;
        m_r = v ? t : '0;
    endtask

    task automatic check_outputs();
        logic        kill, we;
        logic [31:0] npc;
        kill = m_valid && (m_r.exc || m_r.eret);
        npc  = !kill ? 32'h0 : (m_r.eret && !m_r.exc) ? m_epc : ExcVector;
        we   = m_valid && !m_r.exc && !m_r.eret && m_r.wtype != 0 && m_r.wnum != 0;
        check("allowin", {31'h0, wb_allowin_out}, 32'h1);
        check("clr", {31'h0, wb_ClrStpJmp_out}, {31'h0, kill});
        check("new_pc", wb_new_pc_out, npc);
        check("rf_we", {31'h0, rf_we_out}, {31'h0, we});
        check("dbg_wen", {28'h0, debug_wb_rf_wen}, {28'h0, {4{we}}});
        check("dbg_pc", debug_wb_pc, m_valid ? m_r.pc : 32'h0);
        if (we) begin
            check("rf_wnum", {27'h0, rf_wnum_out}, {27'h0, m_r.wnum});
            check("rf_wdata", rf_wdata_out, exp_result(m_r, rt_old_in));
            check("dbg_wnum", {27'h0, debug_wb_rf_wnum}, {27'h0, m_r.wnum});
            check("dbg_wdata", debug_wb_rf_wdata, exp_result(m_r, rt_old_in));
        end
    endtask

    task automatic step(input tr_t t, input logic v);
        mem_valid_in = v;        mem_PC_in = t.pc;           mem_dm_data_in = t.data;
        mem_wnum_in = t.wnum;    mem_sel_wbdata_in = t.sel;  mem_onehot_in = t.onehot;
        mem_lubhw_con_in = t.lubhw; mem_adrl_in = t.adrl;    mem_write_type_in = t.wtype;
        mem_wbdata_in = t.wbdata; mem_llr_we_in = t.llr;     mem_exception_in = t.exc;
        mem_bd_in = t.bd;        mem_ExcCode_in = t.code;    mem_cp0_addr_in = t.cp0a;
        mem_mtc0_data_in = t.mtc0d; mem_error_VAddr_in = t.vaddr; mem_eret_in = t.eret;
        mem_mftc0_op_in = t.op;
        @(posedge clk);
        model_edge(t, v);
        #1;
        check_outputs();
    endtask

    task automatic idle();
        step('0, 1'b0);
    endtask

    // Issue MFC0 into r2 and compare the read value against a constant.
    task automatic read_cp0(input string tag, input logic [7:0] a, input logic [31:0] exp);
        tr_t t;
        t = '0; t.pc = 32'hBFC0_0500; t.op = 2'b01; t.cp0a = a; t.wtype = 3'd1; t.wnum = 5'd2;
        step(t, 1'b1);
        check(tag, rf_wdata_out, exp);
    endtask

    initial begin
        tr_t t;
        int  r;
        rst_n = 1'b0;
        rt_old_in = 32'h0;
        m_valid = 1'b0; m_r = '0;
        m_status = StatusRst; m_cause = 0; m_epc = 0; m_badv = 0;
        t = '0; t.pc = 32'h1234_5678; t.exc = 1'b1; t.wtype = 3'd1; t.wnum = 5'd4;
        step(t, 1'b1);
        step(t, 1'b1);
        check("rst_clr", {31'h0, wb_ClrStpJmp_out}, 32'h0);
        check("rst_allowin", {31'h0, wb_allowin_out}, 32'h1);
        check("rst_pc", debug_wb_pc, 32'h0);
        rst_n = 1'b1;

        t = '0; t.pc = 32'hBFC0_0000; t.sel = 3'b010; t.lubhw = 5'b00001; t.adrl = 2'd3;
        t.data = 32'h80FF_0000; t.wtype = 3'd1; t.wnum = 5'd5;
        step(t, 1'b1);
        check("lb_we", {31'h0, rf_we_out}, 32'h1);
        check("lb_wdata", rf_wdata_out, 32'hFFFF_FF80);

        t = '0; t.pc = 32'hBFC0_0004; t.sel = 3'b100; t.onehot = 8'b0000_0010;
        t.llr = 4'b1100; t.data = 32'hAABB_CCDD; t.wtype = 3'd1; t.wnum = 5'd6;
        rt_old_in = 32'h1122_3344;
        step(t, 1'b1);
        check("lwl_wdata", rf_wdata_out, 32'hCCDD_3344);

        t = '0; t.pc = 32'hBFC0_1004; t.exc = 1'b1; t.code = 5'd4; t.bd = 1'b1;
        t.vaddr = 32'h3; t.wtype = 3'd1; t.wnum = 5'd3;
        step(t, 1'b1);
        check("exc_clr", {31'h0, wb_ClrStpJmp_out}, 32'h1);
        check("exc_new_pc", wb_new_pc_out, 32'hBFC0_0380);
        check("exc_we", {31'h0, rf_we_out}, 32'h0);
        t = '0; t.pc = 32'hBFC0_1008; t.sel = 3'b001; t.wbdata = 32'h1234; t.wtype = 3'd1;
        t.wnum = 5'd7;
        step(t, 1'b1);
        check("flushed_we", {31'h0, rf_we_out}, 32'h0);
        check("flushed_pc", debug_wb_pc, 32'h0);
        read_cp0("epc1", 8'h70, 32'hBFC0_1000);
        read_cp0("cause1", 8'h68, 32'h8000_0010);
        read_cp0("badv1", 8'h40, 32'h0000_0003);
        read_cp0("status1", 8'h60, 32'h0040_0002);

        t = '0; t.pc = 32'h0000_0100; t.exc = 1'b1; t.code = 5'd12; t.vaddr = 32'hDEAD_BEEF;
        step(t, 1'b1);
        idle();
        read_cp0("epc2", 8'h70, 32'hBFC0_1000);
        read_cp0("cause2", 8'h68, 32'h8000_0030);
        read_cp0("badv2", 8'h40, 32'h0000_0003);

        t = '0; t.pc = 32'h0000_0200; t.op = 2'b10; t.cp0a = 8'h70; t.mtc0d = 32'hBFC0_2000;
        step(t, 1'b1);
        t = '0; t.pc = 32'h0000_0204; t.eret = 1'b1;
        step(t, 1'b1);
        check("eret_clr", {31'h0, wb_ClrStpJmp_out}, 32'h1);
        check("eret_new_pc", wb_new_pc_out, 32'hBFC0_2000);
        idle();
        read_cp0("status_eret", 8'h60, 32'h0040_0000);

        t = '0; t.pc = 32'h0000_0300; t.exc = 1'b1; t.code = 5'd5; t.vaddr = 32'h55;
        step(t, 1'b1);
        rst_n = 1'b0;
        step(t, 1'b1);
        check("rst_mid_clr", {31'h0, wb_ClrStpJmp_out}, 32'h0);
        check("rst_mid_npc", wb_new_pc_out, 32'h0);
        check("rst_mid_pc", debug_wb_pc, 32'h0);
        check("rst_mid_wdata", rf_wdata_out, 32'h0);
        rst_n = 1'b1;
        read_cp0("rst_status", 8'h60, StatusRst);
        read_cp0("rst_cause", 8'h68, 32'h0);
        read_cp0("rst_epc", 8'h70, 32'h0);
        read_cp0("rst_badv", 8'h40, 32'h0);
        read_cp0("unmapped", 8'h48, 32'h0);

        for (int n = 0; n < 3000; n++) begin
            t.pc     = $urandom & 32'hFFFF_FFFC;
            t.data   = $urandom;
            t.wnum   = 5'($urandom);
            t.sel    = 3'($urandom);
            t.onehot = 8'(1 << $urandom_range(0, 7));
            t.lubhw  = 5'(1 << $urandom_range(0, 4));
            t.adrl   = 2'($urandom);
            t.wtype  = 3'($urandom);
            t.wbdata = $urandom;
            t.llr    = 4'($urandom);
            t.exc    = ($urandom_range(0, 9) == 0);
            t.bd     = 1'($urandom);
            t.code   = 5'($urandom_range(0, 15));
            r = $urandom_range(0, 5);
            t.cp0a   = (r == 0) ? 8'h60 : (r == 1) ? 8'h68 : (r == 2) ? 8'h70 :
                       (r == 3) ? 8'h40 : (r == 4) ? 8'h48 : 8'h00;
            t.mtc0d  = $urandom;
            t.vaddr  = $urandom;
            t.eret   = ($urandom_range(0, 14) == 0);
            r = $urandom_range(0, 5);
            t.op     = (r == 4) ? 2'b01 : (r == 5) ? 2'b10 : 2'b00;
            rt_old_in = $urandom;
            step(t, $urandom_range(0, 4) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
